// File: rtl/cdc_fifo_gray_rd_engine.sv
// -----------------------------------------------------------------------------
// cdc_fifo_gray_rd_engine
//
// Read-side engine of a gray-pointer FIFO whose storage and write pointer live
// in another clock domain. The remote gray write pointer is synchronized and
// checked for gray integrity. Entries are fetched from the exposed storage into
// a 2-entry output buffer and streamed out. The local gray read pointer is
// published back to the writer.
//
// Handshake: a beat transfers on a rising clk_i edge where valid_o && ready_i.
// valid_o depends only on registered state, never on ready_i. While valid_o is
// high and ready_i is low, data_o and valid_o hold.
//
// Ports:
//   clk_i         sole clock
//   rst_i         asynchronous, active-high reset
//   async_data_i  remote storage array (2**LOG_DEPTH entries of WIDTH bits)
//   async_wptr_i  remote gray write pointer, unsynchronized
//   async_rptr_o  local gray read pointer, straight from a flop
//   data_o        head of the output buffer
//   valid_o       output buffer not empty
//   ready_i       consumer ready
//   flush_i       discard all readable and buffered entries
//   fill_o        entries in storage not yet fetched
//   err_o         sticky gray-integrity error
// -----------------------------------------------------------------------------
module cdc_fifo_gray_rd_engine #(
    parameter int WIDTH       = 32,
    parameter int LOG_DEPTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [2**LOG_DEPTH-1:0][WIDTH-1:0]   async_data_i,
    input  logic [LOG_DEPTH:0]                   async_wptr_i,
    output logic [LOG_DEPTH:0]                   async_rptr_o,
    output logic [WIDTH-1:0]                     data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    input  logic                                 flush_i,
    output logic [LOG_DEPTH:0]                   fill_o,
    output logic                                 err_o
);

    localparam int             PW      = LOG_DEPTH + 1;
    localparam int             DEPTH   = 2 ** LOG_DEPTH;
    localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]  ONE_P   = PW'(1);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Synchronizer: stage 0 samples the raw pointer, the last stage is wptr_s.
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  wptr_prev_q;

    logic [PW-1:0]    rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             err_q, err_d;

    logic [PW-1:0]    wptr_s;
    logic [PW-1:0]    wptr_bin;
    logic [PW-1:0]    rptr_bin;
    logic [PW-1:0]    fill;
    logic [PW-1:0]    wptr_delta;
    logic             multi_bit;
    logic             overfill;
    logic             fetch;
    logic             pop;
    logic [WIDTH-1:0] fetch_data;

    assign wptr_s     = sync_q[SYNC_STAGES-1];
    assign wptr_bin   = gray2bin(wptr_s);
    assign rptr_bin   = gray2bin(rptr_q);
    assign fill       = wptr_bin - rptr_bin;

    // More than one bit toggling between consecutive synchronized samples means
    // the writer broke the gray sequence (or the sync caught a glitch).
    assign wptr_delta = wptr_s ^ wptr_prev_q;
    assign multi_bit  = (wptr_delta & (wptr_delta - ONE_P)) != '0;
    assign overfill   = fill > DEPTH_P;

    assign valid_o    = (cnt_q != 2'd0);
    assign fetch      = (fill != '0) && (cnt_q != 2'd2) && !flush_i;
    assign pop        = valid_o && ready_i && !flush_i;
    assign fetch_data = async_data_i[rptr_bin[LOG_DEPTH-1:0]];

    always_comb begin
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        err_d  = err_q | multi_bit | overfill;

        if (flush_i) begin
            // Jumping to the synchronized write pointer empties the FIFO; the
            // writer is quiescent across a flush so a multi-bit step is safe.
            rptr_d = wptr_s;
            cnt_d  = 2'd0;
        end else begin
            if (fetch) begin
                rptr_d = bin2gray(rptr_bin + ONE_P);
            end
            case ({fetch, pop})
                // Fetch needs cnt < 2 and pop needs cnt > 0, so cnt is 1 here:
                // the fetched entry replaces the departing head.
                2'b11: buf0_d = fetch_data;
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        buf0_d = fetch_data;
                    end else begin
                        buf1_d = fetch_data;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            wptr_prev_q <= '0;
            rptr_q      <= '0;
            cnt_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], async_wptr_i};
            wptr_prev_q <= wptr_s;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            err_q       <= err_d;
        end
    end

    assign async_rptr_o = rptr_q;
    assign data_o       = buf0_q;
    assign fill_o       = fill;
    assign err_o        = err_q;

endmodule
